demux_frame_sequencer: RTL and testbench
========================================

# demux_frame_sequencer

Serial frame front-end that drives the select and data inputs of the 1:4 gate-level demux. It receives a bit-serial frame of one 2-bit channel address followed by PAYLOAD_LEN payload bits. It latches the address onto s0/s1, then streams the payload onto a, so the demux routes the whole payload to one of out1..out4. Outputs are registered, so the demux never sees a select change while a payload bit is on a.

## Interface
- PAYLOAD_LEN, 8: payload bits per frame; legal range 1..255; internal counter is 8 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start; the cycle with start=1 also carries address bit 0 on din.
- din  input  1  serial data; address bit 0 first, then address bit 1, then payload bits in order.
- s0  output  1  demux select bit 0 (address bit 0), registered.
- s1  output  1  demux select bit 1 (address bit 1), registered.
- a  output  1  demux data input, registered; 0 whenever no payload bit is being presented.
- busy  output  1  frame in progress, registered.
- done  output  1  one-cycle pulse while the last payload bit is on a.

## Operation
- Reset: synchronous, active-high. Next state is IDLE; s0, s1, a, busy, done are 0; address holding register and counter are cleared.
- States: IDLE, ADDR, PAYLOAD, FLUSH.
- IDLE
  - start=0: hold; a=0; s0/s1 keep their last values.
  - start=1: capture din into addr_lo; go to ADDR; busy<=1.
- ADDR (one cycle)
  - s0<=addr_lo, s1<=din; cnt<=0; go to PAYLOAD.
- PAYLOAD (PAYLOAD_LEN cycles)
  - Each cycle a<=din and cnt<=cnt+1.
  - When cnt==PAYLOAD_LEN-1, go to FLUSH.
- FLUSH (one cycle)
  - a shows the last payload bit; done=1.
  - With start=0: a<=0, busy<=0, go to IDLE.
  - With start=1: a back-to-back frame is accepted. addr_lo<=din; a<=0; busy stays 1; go to ADDR.
- s0/s1 change only at the end of ADDR, so they are stable for every cycle in which a carries a payload bit.
- start while in ADDR or PAYLOAD is ignored and has no effect on state, counter or outputs.
- done is 0 in every state except FLUSH.
- Reset mid-frame discards the frame. a, busy and s0/s1 are 0 from the cycle after the reset edge.

## Timing
- Cycle numbering: T0 = the cycle in which start=1 is sampled in IDLE or FLUSH; N = PAYLOAD_LEN.
- Address: din carries address bit 0 in T0 and address bit 1 in T1. s0/s1 hold the new address from T2 onward.
- Payload: payload bit k is on din in T(k+2) and on a in T(k+3), for k=0..N-1. Data latency is one cycle.
- busy: high T1..T(N+2) inclusive; it stays high continuously across back-to-back frames.
- done: high only in T(N+2).
- a: 0 in T(N+3) unless a new frame's payload is already present.
- Minimum frame period is N+2 cycles, achieved when start is asserted in FLUSH.
- N=1 edge case: PAYLOAD lasts one cycle (T2); FLUSH is in T3.

## Test plan
- Reset: hold reset=1 for 2 cycles with start=1, din=1 -> s0=s1=a=busy=done=0; release reset -> all remain 0 while start=0.
- Single frame, N=8: start with din in T0=0, T1=1, then payload 1,0,1,1,0,0,1,0 -> s0=0, s1=1 from T2; a=1,0,1,1,0,0,1,0 in T3..T10; done=1 only in T10; busy=1 in T1..T10; a=0 and busy=0 in T11.
- Back-to-back frames: first frame address 11, payload all ones; second start asserted in T10 with address 00 and payload alternating 0,1 -> s0/s1 stay 1/1 through T10 and become 0/0 in T12; a=1 in T10; a=0 in T11 and T12; a=0,1,0,1,... from T13; busy never drops.
- Start ignored: assert start in T4 and T6 of an N=8 frame -> outputs identical to the single-frame case; no extra done pulse.
- Reset mid-payload: assert reset during T5 -> in T6, a=0, busy=0, s0=s1=0, state IDLE; a later start produces a normal frame.
- N=1 parameter build: address 01, payload 1 -> s0=1, s1=0 from T2; a=1 in T3; done=1 in T3; busy=1 in T1..T3.

Source files
------------

// File: rtl/demux_frame_sequencer_if.sv
// demux_frame_sequencer_if
// Groups the serial frame input and the registered demux-side outputs of
// demux_frame_sequencer into one bundle.
//   start : frame start, carries address bit 0 on din in the same cycle
//   din   : serial data (addr bit 0, addr bit 1, then payload bits)
//   s0/s1 : demux select bits
//   a     : demux data bit
//   busy  : frame in progress
//   done  : pulse while the last payload bit is on a
// The master modport is the frame source; the slave modport is the sequencer.
interface demux_frame_sequencer_if;
  logic start;
  logic din;
  logic s0;
  logic s1;
  logic a;
  logic busy;
  logic done;

  modport master (
    output start, din,
    input  s0, s1, a, busy, done
  );

  modport slave (
    input  start, din,
    output s0, s1, a, busy, done
  );
endinterface

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer
// Serial frame front-end for the 1:4 gate-level demux. A frame is a 2-bit
// channel address followed by PAYLOAD_LEN payload bits, all on din. The
// address is latched onto s0/s1, then the payload is streamed onto a with one
// cycle of latency, so the whole payload lands on a single demux output.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of demux_frame_sequencer_if (start, din in;
//           s0, s1, a, busy, done out, all registered)
module demux_frame_sequencer #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  demux_frame_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_e     state_q, state_d;
  logic       addr_lo_q, addr_lo_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       a_q, a_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       lastBit;

  // The payload counter indexes the bit currently on din during PAYLOAD.
  assign lastBit = (cnt_q == LAST_IDX);

  // State and output registers. Everything, including the select bits, is
  // cleared on reset so a partially received frame is discarded completely.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_lo_q <= 1'b0;
      cnt_q     <= 8'd0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      a_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_lo_q <= addr_lo_d;
      cnt_q     <= cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      a_q       <= a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. A start seen in FLUSH goes straight to ADDR so
  // back-to-back frames need no idle gap; start in ADDR/PAYLOAD is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ADDR;
      ADDR:    state_d = PAYLOAD;
      PAYLOAD: if (lastBit) state_d = FLUSH;
      FLUSH:   state_d = bus.start ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. The select bits are
  // only written when leaving ADDR, which keeps them stable while a carries
  // payload. a defaults to 0 so it is low whenever no payload bit is staged,
  // and done is raised on the transfer of the last bit so it coincides with
  // that bit appearing on a.
  always_comb begin
    addr_lo_d = addr_lo_q;
    cnt_d     = cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    a_d       = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_lo_d = bus.din;
          busy_d    = 1'b1;
        end
      end
      ADDR: begin
        s0_d   = addr_lo_q;
        s1_d   = bus.din;
        cnt_d  = 8'd0;
        busy_d = 1'b1;
      end
      PAYLOAD: begin
        a_d    = bus.din;
        cnt_d  = cnt_q + 8'd1;
        done_d = lastBit;
      end
      FLUSH: begin
        if (bus.start) begin
          addr_lo_d = bus.din;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.s0   = s0_q;
  assign bus.s1   = s1_q;
  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// tb_demux_frame_sequencer
// Self-checking bench for demux_frame_sequencer. An N=8 instance is driven
// by a reset/single-frame vector table, directed multi-cycle sequences and
// random traffic, all compared against a timeline reference model; an N=1
// instance is checked with its own small vector table.
module tb_demux_frame_sequencer;

  localparam int N      = 8;
  localparam int MAXCYC = 2048;

  typedef struct {
    bit chk;
    bit reset;
    bit start;
    bit din;
    bit s0;
    bit s1;
    bit a;
    bit busy;
    bit done;
  } vec_t;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;
  int cyc;
  int doneSeen;

  // Reference model: expected outputs laid out on an absolute cycle timeline.
  bit       aExp[MAXCYC];
  bit       busyExp[MAXCYC];
  bit       doneExp[MAXCYC];
  bit       sSet[MAXCYC];
  bit [1:0] sVal[MAXCYC];
  bit [1:0] sCur;
  bit       modelValid;
  int       frameT0;
  bit       addrBit0;

  vec_t tbl[17];
  vec_t tbl1[5];

  demux_frame_sequencer_if bus8();
  demux_frame_sequencer_if bus1();

  demux_frame_sequencer #(.PAYLOAD_LEN(N)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  demux_frame_sequencer #(.PAYLOAD_LEN(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(bit chk, bit r, bit st, bit dn,
                                 bit s0, bit s1, bit a, bit busy, bit done);
    vec_t v;
    v.chk = chk; v.reset = r; v.start = st; v.din = dn;
    v.s0 = s0; v.s1 = s1; v.a = a; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic checkBit(input string name, input logic act, input bit exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input bit es0, input bit es1,
                             input bit ea, input bit ebusy, input bit edone);
    checkBit({tag, ".s0"},   bus8.s0,   es0);
    checkBit({tag, ".s1"},   bus8.s1,   es1);
    checkBit({tag, ".a"},    bus8.a,    ea);
    checkBit({tag, ".busy"}, bus8.busy, ebusy);
    checkBit({tag, ".done"}, bus8.done, edone);
  endtask

  // Advances the reference model by one cycle of inputs. A frame accepted at
  // cycle t0 shows busy in t0+1..t0+N+2, the address on s0/s1 from t0+2,
  // payload bit k (on din at t0+2+k) on a at t0+3+k, and done at t0+N+2.
  task automatic modelStep(input bit r, input bit st, input bit dn);
    int rel;
    if (r) begin
      for (int m = cyc + 1; m <= cyc + N + 4; m++) begin
        aExp[m] = 1'b0; busyExp[m] = 1'b0; doneExp[m] = 1'b0; sSet[m] = 1'b0;
      end
      sSet[cyc + 1] = 1'b1;
      sVal[cyc + 1] = 2'b00;
      frameT0       = -1;
      modelValid    = 1'b1;
    end else begin
      rel = (frameT0 >= 0) ? (cyc - frameT0) : -1;
      if (rel == 1) begin
        sSet[cyc + 1] = 1'b1;
        sVal[cyc + 1] = {dn, addrBit0};
      end
      if (rel >= 2 && rel <= N + 1) aExp[cyc + 1] = dn;
      if (st && (frameT0 < 0 || rel == N + 2)) begin
        frameT0  = cyc;
        addrBit0 = dn;
        for (int m = 1; m <= N + 2; m++) busyExp[cyc + m] = 1'b1;
        doneExp[cyc + N + 2] = 1'b1;
      end else if (rel == N + 2) begin
        frameT0 = -1;
      end
    end
  endtask

  // One N=8 cycle: sample outputs on the falling edge, check against the
  // model (and the vector's own expectations when flagged), then drive.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    if (sSet[cyc]) sCur = sVal[cyc];
    if (bus8.done === 1'b1) doneSeen++;
    if (modelValid)
      checkOutput("model", sCur[0], sCur[1], aExp[cyc], busyExp[cyc], doneExp[cyc]);
    if (v.chk)
      checkOutput("table", v.s0, v.s1, v.a, v.busy, v.done);
    reset     = v.reset;
    bus8.start = v.start;
    bus8.din   = v.din;
    modelStep(v.reset, v.start, v.din);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Drives T0..T(N+1) of one N=8 frame. T(N+2) is left to the caller, so a
  // following driveFrame call starts the next frame in the FLUSH cycle.
  task automatic driveFrame(input bit [1:0] addr, input bit [7:0] payload,
                            input bit [9:0] startMask, input int resetAt);
    bit st;
    bit dn;
    for (int i = 0; i < N + 2; i++) begin
      st = (i == 0) || startMask[i];
      if (i == 0)      dn = addr[0];
      else if (i == 1) dn = addr[1];
      else             dn = payload[i - 2];
      applyStimulus(mkVec(0, (i == resetAt), st, dn, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    vectors    = 0;
    miscompares = 0;
    cyc        = 0;
    doneSeen   = 0;
    sCur       = 2'b00;
    modelValid = 1'b0;
    frameT0    = -1;
    addrBit0   = 1'b0;
    for (int m = 0; m < MAXCYC; m++) begin
      aExp[m] = 0; busyExp[m] = 0; doneExp[m] = 0; sSet[m] = 0; sVal[m] = 2'b00;
    end
    reset      = 1'b1;
    bus8.start = 1'b0;
    bus8.din   = 1'b0;
    bus1.start = 1'b0;
    bus1.din   = 1'b0;

    // Reset with start/din high, then the single frame: addr 10 (s0=0,s1=1),
    // payload 1,0,1,1,0,0,1,0. Fields: chk r st din | s0 s1 a busy done.
    tbl[0]  = mkVec(0, 1, 1, 1,  0, 0, 0, 0, 0);
    tbl[1]  = mkVec(1, 1, 1, 1,  0, 0, 0, 0, 0);
    tbl[2]  = mkVec(1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mkVec(1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[4]  = mkVec(1, 0, 1, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mkVec(1, 0, 0, 1,  0, 0, 0, 1, 0);
    tbl[6]  = mkVec(1, 0, 0, 1,  0, 1, 0, 1, 0);
    tbl[7]  = mkVec(1, 0, 0, 0,  0, 1, 1, 1, 0);
    tbl[8]  = mkVec(1, 0, 0, 1,  0, 1, 0, 1, 0);
    tbl[9]  = mkVec(1, 0, 0, 1,  0, 1, 1, 1, 0);
    tbl[10] = mkVec(1, 0, 0, 0,  0, 1, 1, 1, 0);
    tbl[11] = mkVec(1, 0, 0, 0,  0, 1, 0, 1, 0);
    tbl[12] = mkVec(1, 0, 0, 1,  0, 1, 0, 1, 0);
    tbl[13] = mkVec(1, 0, 0, 0,  0, 1, 1, 1, 0);
    tbl[14] = mkVec(1, 0, 0, 0,  0, 1, 0, 1, 1);
    tbl[15] = mkVec(1, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[16] = mkVec(1, 0, 0, 0,  0, 1, 0, 0, 0);

    // N=1 build: addr 01 (s0=1,s1=0), payload 1.
    tbl1[0] = mkVec(1, 0, 1, 1,  0, 0, 0, 0, 0);
    tbl1[1] = mkVec(1, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl1[2] = mkVec(1, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl1[3] = mkVec(1, 0, 0, 0,  1, 0, 1, 1, 1);
    tbl1[4] = mkVec(1, 0, 0, 0,  1, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) applyStimulus(tbl[i]);

    // Back-to-back: addr 11 all-ones payload, then addr 00 alternating 0,1
    // with its start in the first frame's FLUSH cycle.
    driveFrame(2'b11, 8'hFF, 10'b0, -1);
    driveFrame(2'b00, 8'b10101010, 10'b0, -1);
    idleCycles(3);

    // Start pulses inside ADDR/PAYLOAD must not create a second done.
    doneSeen = 0;
    driveFrame(2'b10, 8'b01001101, 10'b0001010000, -1);
    idleCycles(3);
    checkBit("ignoredStart.doneCount", (doneSeen == 1), 1'b1);

    // Reset during T5, then a normal frame.
    driveFrame(2'b01, 8'b11110000, 10'b0, 5);
    idleCycles(2);
    driveFrame(2'b01, 8'b00110101, 10'b0, -1);
    idleCycles(3);

    // Random traffic with occasional resets.
    for (int k = 0; k < 700; k++) begin
      applyStimulus(mkVec(0, ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 0, 0, 0, 0, 0));
    end
    idleCycles(N + 4);

    // N=1 instance, which has stayed idle since the shared reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkBit("n1.s0",   bus1.s0,   tbl1[i].s0);
      checkBit("n1.s1",   bus1.s1,   tbl1[i].s1);
      checkBit("n1.a",    bus1.a,    tbl1[i].a);
      checkBit("n1.busy", bus1.busy, tbl1[i].busy);
      checkBit("n1.done", bus1.done, tbl1[i].done);
      bus1.start = tbl1[i].start;
      bus1.din   = tbl1[i].din;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
